pckys_reaction_game: RTL and testbench

Parametrised N-player reaction game core, the next-generation TinyTapeout top for the pckys game family, with the standard tt_um pin set. After a pseudo-random delay the display shows "GO"; the first debounced player press wins the round. Scores accumulate until one player reaches ROUNDS_TO_WIN. Adds player-count, timing and debounce parameters, false-start penalties, a reaction-time readout and a win screen.

---
 rtl/pckys_game_pkg.sv | 43 ++++
 rtl/pckys_debounce.sv | 62 ++++++
 rtl/pckys_reaction_game.sv | 216 +++++++++++++++++++++
 tb/tb_pckys_reaction_game.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pckys_game_pkg.sv
// Shared types and constants for the pckys reaction game.
package pckys_game_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      GO     = 3'd2,
      RESULT = 3'd3,
      WIN    = 3'd4
   } state_t;

   // 7-seg patterns, {dp,g,f,e,d,c,b,a}, active-high
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_DASH  = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_ALL   = 8'h7F;
   localparam logic [7:0] SEG_F     = 8'h71;
   localparam logic [7:0] SEG_DP    = 8'h80;

   // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

   // Player number (1-based) to digit; anything else shows '0'
   function automatic logic [7:0] seg_digit(input logic [2:0] n);
      case (n)
         3'd1:    return SEG_1;
         3'd2:    return SEG_2;
         3'd3:    return SEG_3;
         3'd4:    return SEG_4;
         default: return SEG_0;
      endcase
   endfunction

endpackage

// File: rtl/pckys_debounce.sv
// Synchroniser, debouncer and rising-edge pulse for one button input.
// A press gives one pulse DEBOUNCE_CYCLES+3 cycles after the raw rise.
module pckys_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw_in,
   output logic pulse_out
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic          stable_dly_q, stable_dly_d;
   logic          pulse_q, pulse_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // accept the synchronised level once it has differed from the stable one long enough
   always_comb begin
      sync1_d      = raw_in;
      sync2_d      = sync1_q;
      stable_d     = stable_q;
      stable_dly_d = stable_q;
      pulse_d      = stable_q & ~stable_dly_q;
      cnt_d        = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // state registers, frozen while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         pulse_q      <= 1'b0;
         cnt_q        <= '0;
      end else if (ena) begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         pulse_q      <= pulse_d;
         cnt_q        <= cnt_d;
      end
   end

   assign pulse_out = pulse_q;

endmodule

// File: rtl/pckys_reaction_game.sv
// N-player reaction game core with tt_um pin set.
//
// state  | meaning
// IDLE   | '-' shown, waiting for start
// ARMED  | blank, random delay running; a press here is a false start
// GO     | all segments lit, first press wins, react time counting
// RESULT | winner digit / '0' / 'F' held for RESULT_TICKS
// WIN    | match winner digit with dp, start returns to IDLE
module pckys_reaction_game
   import pckys_game_pkg::*;
#(
   parameter int PLAYERS         = 4,
   parameter int TICK_DIV        = 10000,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WAIT_MIN        = 500,
   parameter int WAIT_MASK       = 1023,
   parameter int GO_TIMEOUT      = 2000,
   parameter int RESULT_TICKS    = 1000,
   parameter int ROUNDS_TO_WIN   = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int SW       = $clog2(ROUNDS_TO_WIN + 1);
   localparam int PW       = $clog2(PLAYERS);
   localparam int TKW      = $clog2(TICK_DIV + 1);
   localparam int WAIT_MAX = WAIT_MIN + WAIT_MASK;
   localparam int T_MAX0   = (WAIT_MAX > GO_TIMEOUT) ? WAIT_MAX : GO_TIMEOUT;
   localparam int T_MAX    = (T_MAX0 > RESULT_TICKS) ? T_MAX0 : RESULT_TICKS;
   localparam int TW       = $clog2(T_MAX + 1);

   localparam logic [TKW-1:0] TICK_LAST   = TKW'(TICK_DIV - 1);
   localparam logic [TW-1:0]  WAIT_MIN_T  = TW'(WAIT_MIN);
   localparam logic [15:0]    WAIT_MASK_V = 16'(WAIT_MASK);
   localparam logic [TW-1:0]  GO_LAST     = TW'(GO_TIMEOUT - 1);
   localparam logic [TW-1:0]  RESULT_LAST = TW'(RESULT_TICKS - 1);
   localparam logic [SW-1:0]  SCORE_MAX   = SW'(ROUNDS_TO_WIN);

   logic [PLAYERS:0]             btn_pulse;
   logic                         tick;
   logic                         p_hit;
   logic [PW-1:0]                p_idx;
   logic [2:0]                   p_num;
   logic                         any_won;
   logic [TW-1:0]                rand_wait;

   state_t                       state_q, state_d;
   logic [PLAYERS-1:0][SW-1:0]   score_q, score_d;
   logic [2:0]                   winner_q, winner_d;
   logic [TW-1:0]                wait_cnt_q, wait_cnt_d;
   logic [7:0]                   react_cnt_q, react_cnt_d;
   logic [TKW-1:0]               tick_cnt_q, tick_cnt_d;
   logic [15:0]                  lfsr_q, lfsr_d;
   logic [7:0]                   uo_q, uo_d;
   logic [7:0]                   uio_q, uio_d;

   logic                         unused_ok;
   assign unused_ok = &{1'b0, uio_in, ui_in[7:PLAYERS+1]};

   for (genvar i = 0; i <= PLAYERS; i++) begin : g_btn
      pckys_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk       (clk),
         .rst_n     (rst_n),
         .ena       (ena),
         .raw_in    (ui_in[i]),
         .pulse_out (btn_pulse[i])
      );
   end

   assign tick      = (tick_cnt_q == '0);
   assign rand_wait = WAIT_MIN_T + TW'(lfsr_q & WAIT_MASK_V);
   assign p_num     = 3'(p_idx) + 3'd1;

   // lowest-numbered pressing player wins a same-cycle tie
   always_comb begin
      p_hit = 1'b0;
      p_idx = '0;
      for (int i = PLAYERS - 1; i >= 0; i--) begin
         if (btn_pulse[i+1]) begin
            p_hit = 1'b1;
            p_idx = PW'(i);
         end
      end
   end

   // match is over once any player holds the winning score
   always_comb begin
      any_won = 1'b0;
      for (int i = 0; i < PLAYERS; i++) begin
         if (score_q[i] == SCORE_MAX) any_won = 1'b1;
      end
   end

   // next-state, score, timer and display logic
   always_comb begin
      lfsr_d      = lfsr_next(lfsr_q);
      tick_cnt_d  = tick ? TICK_LAST : tick_cnt_q - 1'b1;
      state_d     = state_q;
      score_d     = score_q;
      winner_d    = winner_q;
      wait_cnt_d  = wait_cnt_q;
      react_cnt_d = react_cnt_q;
      uo_d        = uo_q;
      uio_d       = uio_q;
      case (state_q)
         IDLE: begin
            if (btn_pulse[0]) begin
               state_d    = ARMED;
               wait_cnt_d = rand_wait;
               uo_d       = SEG_BLANK;
            end
         end
         ARMED: begin
            if (p_hit) begin
               if (score_q[p_idx] != '0) score_d[p_idx] = score_q[p_idx] - 1'b1;
               winner_d   = 3'd0;
               uo_d       = SEG_F;
               uio_d      = {5'd0, p_num};
               wait_cnt_d = RESULT_LAST;
               state_d    = RESULT;
            end else if (tick) begin
               if (wait_cnt_q == '0) begin
                  state_d     = GO;
                  react_cnt_d = 8'd0;
                  wait_cnt_d  = GO_LAST;
                  uo_d        = SEG_ALL;
               end else begin
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end
            end
         end
         GO: begin
            if (p_hit) begin
               if (score_q[p_idx] != SCORE_MAX) score_d[p_idx] = score_q[p_idx] + 1'b1;
               winner_d   = p_num;
               uo_d       = seg_digit(p_num);
               uio_d      = react_cnt_q;
               wait_cnt_d = RESULT_LAST;
               state_d    = RESULT;
            end else if (tick) begin
               if (react_cnt_q != 8'hFF) react_cnt_d = react_cnt_q + 8'd1;
               if (wait_cnt_q == '0) begin
                  winner_d   = 3'd0;
                  uo_d       = SEG_0;
                  uio_d      = 8'hFF;
                  wait_cnt_d = RESULT_LAST;
                  state_d    = RESULT;
               end else begin
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end
            end
         end
         RESULT: begin
            if (tick) begin
               if (wait_cnt_q != '0) begin
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end else if (any_won) begin
                  state_d = WIN;
                  uo_d    = seg_digit(winner_q) | SEG_DP;
               end else begin
                  state_d    = ARMED;
                  wait_cnt_d = rand_wait;
                  uo_d       = SEG_BLANK;
               end
            end
         end
         WIN: begin
            if (btn_pulse[0]) begin
               state_d  = IDLE;
               score_d  = '0;
               winner_d = 3'd0;
               uio_d    = 8'd0;
               uo_d     = SEG_DASH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // all game state, frozen while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         score_q     <= '0;
         winner_q    <= 3'd0;
         wait_cnt_q  <= '0;
         react_cnt_q <= 8'd0;
         tick_cnt_q  <= '0;
         lfsr_q      <= LFSR_SEED;
         uo_q        <= SEG_DASH;
         uio_q       <= 8'd0;
      end else if (ena) begin
         state_q     <= state_d;
         score_q     <= score_d;
         winner_q    <= winner_d;
         wait_cnt_q  <= wait_cnt_d;
         react_cnt_q <= react_cnt_d;
         tick_cnt_q  <= tick_cnt_d;
         lfsr_q      <= lfsr_d;
         uo_q        <= uo_d;
         uio_q       <= uio_d;
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = uio_q;
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_pckys_reaction_game.sv
// Bench for pckys_reaction_game with shortened timing parameters.
module tb_pckys_reaction_game;
   import pckys_game_pkg::*;

   localparam int PLAYERS       = 4;
   localparam int TICK_DIV      = 4;
   localparam int DEB           = 2;
   localparam int WAIT_MIN      = 3;
   localparam int WAIT_MASK     = 3;
   localparam int GO_TIMEOUT    = 20;
   localparam int RESULT_TICKS  = 2;
   localparam int ROUNDS_TO_WIN = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   always #5 clk = ~clk;

   pckys_reaction_game #(
      .PLAYERS         (PLAYERS),
      .TICK_DIV        (TICK_DIV),
      .DEBOUNCE_CYCLES (DEB),
      .WAIT_MIN        (WAIT_MIN),
      .WAIT_MASK       (WAIT_MASK),
      .GO_TIMEOUT      (GO_TIMEOUT),
      .RESULT_TICKS    (RESULT_TICKS),
      .ROUNDS_TO_WIN   (ROUNDS_TO_WIN)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   typedef struct {
      string      name;
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   typedef enum {K_WIN, K_FALSE, K_TIMEOUT} kind_t;

   typedef struct {
      string      name;
      kind_t      kind;
      logic [7:0] buttons;
      logic [7:0] uo;
      logic [7:0] uio;
      logic [7:0] scores;   // {p4,p3,p2,p1}, 2 bits each
   } row_t;

   exp_t sb_q[$];
   row_t rows[8];
   int   checks = 0;
   int   errors = 0;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [7:0] uo, input logic [7:0] uio);
      exp_t e;
      e.name = name;
      e.uo   = uo;
      e.uio  = uio;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: no expectation queued");
      end else begin
         e = sb_q.pop_front();
         check8({e.name, " uo_out"}, uo_out, e.uo);
         check8({e.name, " uio_out"}, uio_out, e.uio);
      end
   endtask

   task automatic wait_uo(input logic [7:0] val, input int bound, input string name);
      int n = 0;
      while (uo_out !== val && n < bound) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (uo_out !== val) begin
         errors++;
         $display("FAIL %s: timed out, uo_out %02h, expected %02h", name, uo_out, val);
      end
   endtask

   task automatic wait_change(input logic [7:0] prev, input int bound, input string name);
      int n = 0;
      while (uo_out === prev && n < bound) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (uo_out === prev) begin
         errors++;
         $display("FAIL %s: timed out, uo_out stuck at %02h", name, prev);
      end
   endtask

   // hold long enough to pass the debouncer, then release
   task automatic press(input logic [7:0] mask);
      ui_in = mask;
      repeat (6) @(negedge clk);
      ui_in = 8'h00;
   endtask

   task automatic set_row(input int i, input string name, input kind_t kind, input logic [7:0] buttons,
                          input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] scores);
      rows[i].name    = name;
      rows[i].kind    = kind;
      rows[i].buttons = buttons;
      rows[i].uo      = uo;
      rows[i].uio     = uio;
      rows[i].scores  = scores;
   endtask

   // GO presses land 15 edges after GO entry, i.e. after the third tick
   task automatic run_row(input row_t row);
      logic [7:0] prev;
      if (row.kind == K_FALSE) wait_uo(SEG_BLANK, 200, {row.name, " armed"});
      else                     wait_uo(SEG_ALL, 200, {row.name, " go"});
      if (row.kind == K_WIN) repeat (9) @(negedge clk);
      sb_push(row.name, row.uo, row.uio);
      prev = uo_out;
      if (row.kind != K_TIMEOUT) press(row.buttons);
      wait_change(prev, 200, row.name);
      sb_check();
      check8({row.name, " scores"}, dut.score_q, row.scores);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      int         first;
      int         d;
      logic       changed;
      logic [7:0] wsave;
      logic [7:0] prev;

      set_row(0, "p2 wins",       K_WIN,     8'h04, SEG_2, 8'd3,  8'h04);
      set_row(1, "p1+p3 tie",     K_WIN,     8'h0A, SEG_1, 8'd3,  8'h05);
      set_row(2, "p4 false at 0", K_FALSE,   8'h10, SEG_F, 8'd4,  8'h05);
      set_row(3, "p4 wins",       K_WIN,     8'h10, SEG_4, 8'd3,  8'h45);
      set_row(4, "p4 false at 1", K_FALSE,   8'h10, SEG_F, 8'd4,  8'h05);
      set_row(5, "go timeout",    K_TIMEOUT, 8'h00, SEG_0, 8'hFF, 8'h05);
      set_row(6, "p2 wins a",     K_WIN,     8'h04, SEG_2, 8'd3,  8'h04);
      set_row(7, "p2 wins b",     K_WIN,     8'h04, SEG_2, 8'd3,  8'h08);

      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h5A;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check8("reset uo_out", uo_out, SEG_DASH);
      check8("reset uio_out", uio_out, 8'h00);
      check8("uio_oe", uio_oe, 8'hFF);
      check8("reset scores", dut.score_q, 8'h00);

      // one-cycle glitch on start and player 1
      ui_in = 8'h03;
      @(negedge clk);
      ui_in = 8'h00;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (dut.btn_pulse[1]) n++;
      end
      check8("glitch pulses", 8'(n), 8'd0);
      check8("glitch idle", uo_out, SEG_DASH);

      // held press on player 1
      ui_in = 8'h02;
      n     = 0;
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (dut.btn_pulse[1]) begin
            n++;
            if (first == 0) first = k;
         end
      end
      ui_in = 8'h00;
      repeat (8) @(negedge clk);
      check8("pulse latency", 8'(first), 8'(DEB + 3));
      check8("pulse count", 8'(n), 8'd1);
      check8("idle ignores player", uo_out, SEG_DASH);

      // start the match
      sb_push("start", SEG_BLANK, 8'h00);
      prev = uo_out;
      press(8'h01);
      wait_change(prev, 50, "start");
      sb_check();

      // freeze with ena low during ARMED
      d = 0;
      repeat (3) begin
         @(negedge clk);
         d++;
      end
      wsave   = 8'(dut.wait_cnt_q);
      ena     = 1'b0;
      changed = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (uo_out !== SEG_BLANK || uio_out !== 8'h00) changed = 1'b1;
      end
      check8("freeze outputs", 8'(changed), 8'd0);
      check8("freeze state", 8'(dut.state_q), 8'(ARMED));
      check8("freeze wait_cnt", 8'(dut.wait_cnt_q), wsave);
      ena = 1'b1;
      while (uo_out !== SEG_ALL && d < 100) begin
         @(negedge clk);
         d++;
      end
      checks++;
      if (d < 13 || d > 28) begin
         errors++;
         $display("FAIL armed delay: %0d enabled cycles, expected 13..28", d);
      end

      for (int r = 0; r < 6; r++) run_row(rows[r]);

      // asynchronous reset in the middle of GO
      wait_uo(SEG_ALL, 200, "pre-reset go");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check8("async reset uo_out", uo_out, SEG_DASH);
      check8("async reset uio_out", uio_out, 8'h00);
      @(negedge clk);
      check8("async reset scores", dut.score_q, 8'h00);
      check8("async reset state", 8'(dut.state_q), 8'(IDLE));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      sb_push("restart", SEG_BLANK, 8'h00);
      prev = uo_out;
      press(8'h01);
      wait_change(prev, 50, "restart");
      sb_check();

      for (int r = 6; r < 8; r++) run_row(rows[r]);

      sb_push("win screen", SEG_2 | SEG_DP, 8'd3);
      prev = uo_out;
      wait_change(prev, 100, "win screen");
      sb_check();

      sb_push("back to idle", SEG_DASH, 8'h00);
      prev = uo_out;
      press(8'h01);
      wait_change(prev, 50, "back to idle");
      sb_check();
      check8("cleared scores", dut.score_q, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
